// File: rtl/dig_map_controller.sv
// Dig map controller: 32x24 grid of 16x16 px cells tracking which cells the digger has cleared.
// Re-initialises on reset or level_start (column-by-column clear, then seed shaft), then accepts digs.
module dig_map_controller #(
    parameter int SEED_COL  = 15,
    parameter int SEED_ROWS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        level_start,
    input  logic        dig_valid,
    output logic        dig_ready,
    input  logic [9:0]  dig_x,
    input  logic [9:0]  dig_y,
    input  logic [4:0]  q_col,
    input  logic [4:0]  q_row,
    output logic        q_dug,
    output logic [23:0] dug_state [0:31],
    output logic        new_dig,
    output logic [9:0]  dug_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        SEED  = 2'd1,
        IDLE  = 2'd2
    } state_t;

    localparam logic [4:0]  SEED_COL_IDX = 5'(SEED_COL);
    localparam logic [23:0] SEED_MASK    = (SEED_ROWS == 0) ? 24'h000000
                                         : (24'hFF_FFFF >> (24 - SEED_ROWS));
    localparam logic [9:0]  SEED_COUNT   = 10'(SEED_ROWS);
    localparam logic [9:0]  MAX_COUNT    = 10'd768;

    state_t      state_r;
    state_t      state_next_s;
    logic [4:0]  col_cnt_r;
    logic [4:0]  col_cnt_next_s;

    logic [9:0]  dig_y_off_s;
    logic [4:0]  dig_col_s;
    logic [4:0]  dig_row_s;
    logic        dig_in_range_s;
    logic        dig_accept_s;
    logic        cell_was_dug_s;
    logic        unused_s;

    assign busy      = (state_r != IDLE);
    assign dig_ready = (state_r == IDLE) && !level_start;
    assign unused_s  = ^{dig_x[3:0], dig_y_off_s[9], dig_y_off_s[3:0]};

    // Next-state and column counter; level_start restarts initialisation from any state.
    always_comb begin
        state_next_s   = state_r;
        col_cnt_next_s = col_cnt_r;
        if (level_start) begin
            state_next_s   = CLEAR;
            col_cnt_next_s = 5'd0;
        end else begin
            case (state_r)
                CLEAR: begin
                    col_cnt_next_s = col_cnt_r + 5'd1;
                    if (col_cnt_r == 5'd31) begin
                        state_next_s = SEED;
                    end else begin
                        state_next_s = CLEAR;
                    end
                end
                SEED: begin
                    state_next_s   = IDLE;
                    col_cnt_next_s = 5'd0;
                end
                IDLE: begin
                    state_next_s   = IDLE;
                    col_cnt_next_s = 5'd0;
                end
                default: begin
                    state_next_s   = CLEAR;
                    col_cnt_next_s = 5'd0;
                end
            endcase
        end
    end

    // Pixel-to-cell mapping of the dig request; the grid starts 96 px down the screen.
    always_comb begin
        dig_y_off_s    = dig_y - 10'd96;
        dig_col_s      = dig_x[8:4];
        dig_row_s      = dig_y_off_s[8:4];
        dig_in_range_s = (dig_x[9] == 1'b0) && (dig_y >= 10'd96) && (dig_y <= 10'd479);
        dig_accept_s   = dig_valid && dig_ready;
        if (dig_in_range_s) begin
            cell_was_dug_s = dug_state[dig_col_s][dig_row_s];
        end else begin
            cell_was_dug_s = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= CLEAR;
            col_cnt_r <= 5'd0;
        end else begin
            state_r   <= state_next_s;
            col_cnt_r <= col_cnt_next_s;
        end
    end

    // Grid, dug counter, new-dig pulse and registered query port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 32; c++) begin
                dug_state[c] <= 24'h000000;
            end
            dug_count <= 10'd0;
            new_dig   <= 1'b0;
            q_dug     <= 1'b0;
        end else begin
            new_dig <= 1'b0;
            if (q_row < 5'd24) begin
                q_dug <= dug_state[q_col][q_row];
            end else begin
                q_dug <= 1'b0;
            end
            if (level_start) begin
                dug_count <= 10'd0;
            end else begin
                case (state_r)
                    CLEAR: begin
                        dug_state[col_cnt_r] <= 24'h000000;
                        dug_count            <= 10'd0;
                    end
                    SEED: begin
                        dug_state[SEED_COL_IDX] <= SEED_MASK;
                        dug_count               <= SEED_COUNT;
                    end
                    IDLE: begin
                        // Out-of-range digs report the cell as already dug, so they are consumed silently.
                        if (dig_accept_s && !cell_was_dug_s) begin
                            dug_state[dig_col_s][dig_row_s] <= 1'b1;
                            new_dig                         <= 1'b1;
                            if (dug_count < MAX_COUNT) begin
                                dug_count <= dug_count + 10'd1;
                            end else begin
                                dug_count <= dug_count;
                            end
                        end else begin
                            dug_count <= dug_count;
                        end
                    end
                    default: begin
                        dug_count <= dug_count;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dig_map_controller.sv
// Self-checking bench for dig_map_controller: directed scenarios plus randomized digs,
// compared cycle by cycle against a cell-array reference model with an init countdown.
module tb_dig_map_controller;

    localparam int SEED_COL  = 15;
    localparam int SEED_ROWS = 6;
    localparam int INIT_CYCLES = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        level_start = 1'b0;
    logic        dig_valid = 1'b0;
    logic        dig_ready;
    logic [9:0]  dig_x = 10'd0;
    logic [9:0]  dig_y = 10'd0;
    logic [4:0]  q_col = 5'd0;
    logic [4:0]  q_row = 5'd0;
    logic        q_dug;
    logic [23:0] dug_state [0:31];
    logic        new_dig;
    logic [9:0]  dug_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // reference model
    bit [23:0] m_grid [32];
    int        m_count = 0;
    int        m_init  = INIT_CYCLES;
    bit        m_new   = 1'b0;
    bit        m_q     = 1'b0;
    bit        m_q_valid = 1'b0;

    dig_map_controller #(.SEED_COL(SEED_COL), .SEED_ROWS(SEED_ROWS)) dut (
        .clk(clk), .reset(reset), .level_start(level_start),
        .dig_valid(dig_valid), .dig_ready(dig_ready),
        .dig_x(dig_x), .dig_y(dig_y), .q_col(q_col), .q_row(q_row),
        .q_dug(q_dug), .dug_state(dug_state), .new_dig(new_dig),
        .dug_count(dug_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 32; c++) m_grid[c] = '0;
    endtask

    // Applies the inputs present at this clock edge to the model.
    task automatic model_edge();
        int c;
        int r;
        m_q_valid = 1'b0;
        if (reset) begin
            model_clear();
            m_count = 0; m_new = 1'b0; m_q = 1'b0; m_q_valid = 1'b1;
            m_init = INIT_CYCLES;
        end else begin
            m_new = 1'b0;
            if (m_init == 0) begin
                m_q = (q_row < 24) ? m_grid[q_col][q_row] : 1'b0;
                m_q_valid = 1'b1;
            end
            if (level_start) begin
                m_init = INIT_CYCLES;
                m_count = 0;
            end else if (m_init > 0) begin
                m_init--;
                if (m_init == 0) begin
                    model_clear();
                    for (int k = 0; k < SEED_ROWS; k++) m_grid[SEED_COL][k] = 1'b1;
                    m_count = SEED_ROWS;
                end
            end else if (dig_valid && dig_x <= 511 && dig_y >= 96 && dig_y <= 479) begin
                c = int'(dig_x) / 16;
                r = (int'(dig_y) - 96) / 16;
                if (!m_grid[c][r]) begin
                    m_grid[c][r] = 1'b1;
                    m_new = 1'b1;
                    if (m_count < 768) m_count++;
                end
            end
        end
    endtask

    task automatic tick();
        #2;
        if (!reset) chk("dig_ready", {31'd0, dig_ready}, {31'd0, (m_init == 0) && !level_start});
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_init != 0});
        chk("dug_count", {22'd0, dug_count}, 32'(m_count));
        chk("new_dig", {31'd0, new_dig}, {31'd0, m_new});
        if (m_q_valid) chk("q_dug", {31'd0, q_dug}, {31'd0, m_q});
        if (m_init == 0 && !reset) begin
            for (int c = 0; c < 32; c++) chk($sformatf("col%0d", c), {8'd0, dug_state[c]}, {8'd0, m_grid[c]});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic dig_once(input int x, input int y);
        dig_x = 10'(x); dig_y = 10'(y); dig_valid = 1'b1;
        tick();
        dig_valid = 1'b0;
        tick();
    endtask

    initial begin
        // reset and automatic initialisation
        model_clear();
        run(2);
        reset = 1'b0;
        run(INIT_CYCLES);
        chk("seed_col", {8'd0, dug_state[15]}, 32'h0000_003F);
        chk("seed_count", {22'd0, dug_count}, 32'd6);
        #2;
        chk("ready_after_init", {31'd0, dig_ready}, 32'd1);

        // first dig, then repeat on the same cell
        dig_once(100, 200);
        chk("cell_6_6", {31'd0, dug_state[6][6]}, 32'd1);
        chk("count_7", {22'd0, dug_count}, 32'd7);
        dig_once(100, 200);
        chk("count_still_7", {22'd0, dug_count}, 32'd7);

        // range boundaries
        dig_once(511, 479);
        dig_once(512, 200);
        dig_once(300, 95);
        chk("cell_31_23", {31'd0, dug_state[31][23]}, 32'd1);
        chk("count_8", {22'd0, dug_count}, 32'd8);

        // level_start with a concurrent dig
        level_start = 1'b1; dig_valid = 1'b1; dig_x = 10'd20; dig_y = 10'd100;
        tick();
        level_start = 1'b0; dig_valid = 1'b0;
        run(INIT_CYCLES);

        // level_start restarted mid-CLEAR, then queries
        level_start = 1'b1; tick(); level_start = 1'b0;
        run(9);
        level_start = 1'b1; tick(); level_start = 1'b0;
        run(INIT_CYCLES);
        q_col = 5'd15; q_row = 5'd5; tick();
        chk("q_seed_row5", {31'd0, q_dug}, 32'd1);
        q_row = 5'd30; tick();
        chk("q_row30", {31'd0, q_dug}, 32'd0);

        // reset on the cycle of an accepted dig
        dig_valid = 1'b1; dig_x = 10'd40; dig_y = 10'd300; reset = 1'b1;
        tick();
        reset = 1'b0; dig_valid = 1'b0;
        chk("reset_dig_count", {22'd0, dug_count}, 32'd0);
        run(INIT_CYCLES);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            dig_valid   = ($urandom_range(0, 3) != 0);
            dig_x       = 10'($urandom_range(0, 600));
            dig_y       = 10'($urandom_range(60, 520));
            q_col       = 5'($urandom_range(0, 31));
            q_row       = 5'($urandom_range(0, 31));
            level_start = ($urandom_range(0, 63) == 0);
            reset       = ($urandom_range(0, 127) == 0);
            tick();
        end
        reset = 1'b0; level_start = 1'b0; dig_valid = 1'b0;
        level_start = 1'b1; tick(); level_start = 1'b0;
        run(INIT_CYCLES);

        // fill every cell, then keep digging to exercise the counter ceiling
        for (int c = 0; c < 32; c++) begin
            for (int r = 0; r < 24; r++) begin
                dig_valid = 1'b1;
                dig_x = 10'(c * 16 + $urandom_range(0, 15));
                dig_y = 10'(96 + r * 16 + $urandom_range(0, 15));
                q_col = 5'(c); q_row = 5'(r);
                tick();
            end
        end
        chk("full_count", {22'd0, dug_count}, 32'd768);
        dig_x = 10'd0; dig_y = 10'd96;
        run(3);
        chk("full_count_hold", {22'd0, dug_count}, 32'd768);
        dig_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
